// File: rtl/emulib_ingress_pipe_buf_imp_pkg.sv
// Shared sizing helpers for the buffered ingress pipe and its prefetch FIFO.
package emulib_ingress_pipe_buf_imp_pkg;

   // Pointer width for a power-of-two FIFO; pointers wrap naturally at DEPTH.
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Occupancy must represent 0..DEPTH inclusive.
   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/emulib_ingress_pipe_buf_imp_fifo.sv
// Regfile prefetch FIFO; zero-latency head read, write visible at head next cycle.
// No internal flow control: caller must never push when full or pop when empty.
module emulib_ingress_pipe_buf_imp_fifo
   import emulib_ingress_pipe_buf_imp_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [DATA_WIDTH-1:0]       push_data,
   input  logic                        pop,
   output logic [DATA_WIDTH-1:0]       head_data,
   output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

   localparam int AW = ptr_w(DEPTH);
   localparam int OW = occ_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      occupancy <= occupancy + OW'(1);
         else if (pop && !push) occupancy <= occupancy - OW'(1);
      end
   end

   // Storage carries no reset: contents are only observable behind occupancy.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/emulib_ingress_pipe_buf_imp.sv
// Ingress pipe with DEPTH-word prefetch FIFO; tick fires same cycle a head word or empty token exists.
// Host stalls on full FIFO; empty tokens held until a tick with an empty FIFO consumes them.
module emulib_ingress_pipe_buf_imp
   import emulib_ingress_pipe_buf_imp_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 32
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   output logic                        valid,
   output logic [DATA_WIDTH-1:0]       data,
   input  logic                        tk_enable_valid,
   output logic                        tk_enable_ready,
   output logic                        tk_data_valid,
   input  logic                        tk_data_ready,
   input  logic                        stream_valid,
   input  logic [DATA_WIDTH-1:0]       stream_data,
   input  logic                        stream_empty,
   output logic                        stream_ready,
   output logic [$clog2(DEPTH+1)-1:0]  occupancy,
   output logic [CNT_WIDTH-1:0]        stall_cycles
);

   localparam int OW = occ_w(DEPTH);

   logic fifo_ne;
   logic full;
   logic bypass_empty;
   logic head_avail;
   logic tick_ok;
   logic fire;
   logic push;
   logic pop;

   assign fifo_ne      = (occupancy != '0);
   assign full         = (occupancy == OW'(DEPTH));
   assign bypass_empty = !fifo_ne && stream_valid && stream_empty;
   assign head_avail   = fifo_ne || bypass_empty;

   // A disabled tick needs nothing from the host, so it is always satisfiable.
   assign tick_ok         = !enable || head_avail;
   assign tk_data_valid   = tk_enable_valid && tick_ok;
   assign tk_enable_ready = tk_data_ready && tick_ok;
   assign fire            = tk_enable_valid && tk_data_ready && tick_ok;

   assign valid = enable && fifo_ne;
   assign pop   = fire && enable && fifo_ne;
   assign push  = stream_valid && !stream_empty && !full;

   // Ready never depends on pop for data words, keeping host ready off the tick path.
   assign stream_ready = stream_empty ? (fire && enable && !fifo_ne) : !full;

   emulib_ingress_pipe_buf_imp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  (stream_data),
      .pop        (pop),
      .head_data  (data),
      .occupancy  (occupancy)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (tk_enable_valid && enable && !head_avail && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_emulib_ingress_pipe_buf_imp.sv
// Directed bench for the buffered ingress pipe: prefetch, consume, stall, bypass, full+pop, reset.
// Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
module tb_emulib_ingress_pipe_buf_imp;

   localparam int DW = 8;
   localparam int DP = 4;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          valid;
   logic [DW-1:0] data;
   logic          tk_enable_valid;
   logic          tk_enable_ready;
   logic          tk_data_valid;
   logic          tk_data_ready;
   logic          stream_valid;
   logic [DW-1:0] stream_data;
   logic          stream_empty;
   logic          stream_ready;
   logic [2:0]    occupancy;
   logic [CW-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   emulib_ingress_pipe_buf_imp #(
      .DATA_WIDTH (DW),
      .DEPTH      (DP),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .valid           (valid),
      .data            (data),
      .tk_enable_valid (tk_enable_valid),
      .tk_enable_ready (tk_enable_ready),
      .tk_data_valid   (tk_data_valid),
      .tk_data_ready   (tk_data_ready),
      .stream_valid    (stream_valid),
      .stream_data     (stream_data),
      .stream_empty    (stream_empty),
      .stream_ready    (stream_ready),
      .occupancy       (occupancy),
      .stall_cycles    (stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      stream_valid = 1'b1;
      stream_empty = 1'b0;
      stream_data  = d;
      #2;
      chk("push_rdy", 32'(stream_ready), 32'd1);
      @(negedge clk);
      stream_valid = 1'b0;
   endtask

   task automatic set_tick(input logic en, input logic tkv, input logic tkr);
      enable          = en;
      tk_enable_valid = tkv;
      tk_data_ready   = tkr;
   endtask

   logic [DW-1:0] exp_seq [4];

   initial begin
      rst = 1'b1;
      set_tick(1'b0, 1'b0, 1'b0);
      stream_valid = 1'b0;
      stream_data  = '0;
      stream_empty = 1'b0;

      // Reset state
      @(negedge clk);
      #2;
      chk("rst_occ",     32'(occupancy),       32'd0);
      chk("rst_valid",   32'(valid),           32'd0);
      chk("rst_stall",   stall_cycles,         32'd0);
      chk("rst_srdy",    32'(stream_ready),    32'd1);
      chk("rst_tkerdy",  32'(tk_enable_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Prefetch four words with no ticks, fifth is refused
      exp_seq[0] = 8'h0A; exp_seq[1] = 8'h0B; exp_seq[2] = 8'h0C; exp_seq[3] = 8'h0D;
      for (int i = 0; i < 4; i++) push_word(exp_seq[i]);
      stream_valid = 1'b1;
      stream_data  = 8'h0E;
      #2;
      chk("pf_occ",  32'(occupancy),    32'd4);
      chk("pf_srdy", 32'(stream_ready), 32'd0);
      stream_valid = 1'b0;
      @(negedge clk);

      // Consume in order, one per fire
      set_tick(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("cons_valid", 32'(valid),         32'd1);
         chk("cons_tkdv",  32'(tk_data_valid), 32'd1);
         chk("cons_data",  32'(data),          32'(exp_seq[i]));
         @(negedge clk);
      end
      #2;
      chk("cons_occ", 32'(occupancy), 32'd0);

      // Stall for five cycles with no host word
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("stall_tkdv",  32'(tk_data_valid),   32'd0);
         chk("stall_tkerd", 32'(tk_enable_ready), 32'd0);
         @(negedge clk);
      end
      #2;
      chk("stall_cnt5", stall_cycles, 32'd5);
      stream_valid = 1'b1;
      stream_data  = 8'h5A;
      #1;
      chk("stall_srdy",   32'(stream_ready),  32'd1);
      chk("stall_nocut",  32'(tk_data_valid), 32'd0);
      @(negedge clk);
      stream_valid = 1'b0;
      #2;
      chk("late_tkdv",  32'(tk_data_valid), 32'd1);
      chk("late_valid", 32'(valid),         32'd1);
      chk("late_data",  32'(data),          32'h5A);
      chk("late_stall", stall_cycles,       32'd6);
      @(negedge clk);

      // Empty-token bypass on an empty FIFO
      stream_valid = 1'b1;
      stream_empty = 1'b1;
      #2;
      chk("byp_tkdv",  32'(tk_data_valid),   32'd1);
      chk("byp_tkerd", 32'(tk_enable_ready), 32'd1);
      chk("byp_valid", 32'(valid),           32'd0);
      chk("byp_srdy",  32'(stream_ready),    32'd1);
      @(negedge clk);
      stream_valid = 1'b0;
      #2;
      chk("byp_occ",   32'(occupancy), 32'd0);
      chk("byp_stall", stall_cycles,   32'd6);

      // Empty token with no tick pending is held
      set_tick(1'b1, 1'b0, 1'b1);
      stream_valid = 1'b1;
      #1;
      chk("hold_srdy", 32'(stream_ready), 32'd0);
      stream_valid = 1'b0;
      stream_empty = 1'b0;
      @(negedge clk);

      // Disabled tick completes without host data
      set_tick(1'b0, 1'b1, 1'b1);
      #2;
      chk("dis_tkerd", 32'(tk_enable_ready), 32'd1);
      chk("dis_tkdv",  32'(tk_data_valid),   32'd1);
      chk("dis_valid", 32'(valid),           32'd0);
      @(negedge clk);
      set_tick(1'b0, 1'b0, 1'b0);
      #2;
      chk("dis_occ",   32'(occupancy), 32'd0);
      chk("dis_stall", stall_cycles,   32'd6);
      @(negedge clk);

      // Full FIFO: pop refuses the concurrent host word, accepted next cycle
      for (int i = 1; i <= 4; i++) push_word(DW'(i));
      stream_valid = 1'b1;
      stream_data  = 8'h55;
      set_tick(1'b1, 1'b1, 1'b1);
      #2;
      chk("full_occ",  32'(occupancy),    32'd4);
      chk("full_srdy", 32'(stream_ready), 32'd0);
      chk("full_data", 32'(data),         32'd1);
      @(negedge clk);
      set_tick(1'b1, 1'b0, 1'b1);
      #2;
      chk("fp_occ3", 32'(occupancy),    32'd3);
      chk("fp_srdy", 32'(stream_ready), 32'd1);
      @(negedge clk);
      stream_valid = 1'b0;
      #2;
      chk("fp_occ4", 32'(occupancy), 32'd4);
      chk("fp_head", 32'(data),      32'd2);

      // Mid-burst reset at occupancy 3
      set_tick(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      set_tick(1'b1, 1'b0, 1'b1);
      #2;
      chk("mr_occ3", 32'(occupancy), 32'd3);
      chk("mr_head", 32'(data),      32'd3);
      rst = 1'b1;
      #1;
      chk("mr_occ",   32'(occupancy),  32'd0);
      chk("mr_valid", 32'(valid),      32'd0);
      chk("mr_stall", stall_cycles,    32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Post-reset push lands at the head
      set_tick(1'b0, 1'b0, 1'b0);
      push_word(8'h77);
      #2;
      chk("post_occ",  32'(occupancy), 32'd1);
      chk("post_data", 32'(data),      32'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
